// File: rtl/bch_uart_cmd_rx.sv
// UART 8N1 command receiver: deserialises bytes, parses the 5-byte A5 frame and
// hands one validated BCH configuration word downstream over valid/ready.
module bch_uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int TIMEOUT_CLKS = 104160,
  parameter int MAX_ERRORS   = 13
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       uart_rx,
  input  logic       cfg_ready,
  input  logic       clr_status,
  output logic       cfg_valid,
  output logic       cfg_bch_coding,
  output logic       cfg_gen_noise,
  output logic       cfg_rand_errors,
  output logic [7:0] cfg_num_errors,
  output logic [7:0] cfg_data,
  output logic [7:0] frame_err_cnt,
  output logic [7:0] chk_err_cnt,
  output logic       overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;
  localparam logic [7:0]    NERR_MAX  = 8'(MAX_ERRORS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_SYNC, P_CTRL, P_NERR, P_DATA, P_CHK} p_state_t;

  rx_state_t rx_state, rx_next;
  p_state_t  p_state, p_next;

  logic          rx_s1, rx_s2, rx_prev;
  logic          rx_fall;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          samp;
  logic          byte_valid, stop_err;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic [7:0]    ctrl_r, nerr_r, data_r;
  logic          frame_done, frame_good, frame_bad;
  logic          hs;

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    samp    = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (bit_cnt == HALF_LAST) begin
        samp    = 1'b1;
        rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA:  if (bit_cnt == BIT_LAST) begin
        samp = 1'b1;
        if (bit_idx == 3'd7) rx_next = RX_STOP;
      end
      RX_STOP:  if (bit_cnt == BIT_LAST) begin
        samp    = 1'b1;
        rx_next = RX_IDLE;
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      bit_cnt    <= (rx_state == RX_IDLE || samp) ? '0 : bit_cnt + 1'b1;
      byte_valid <= (rx_state == RX_STOP) && samp && rx_s2;
      stop_err   <= (rx_state == RX_STOP) && samp && !rx_s2;
      if (rx_state == RX_START) bit_idx <= '0;
      if (rx_state == RX_DATA && samp) begin
        shreg   <= {rx_s2, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // Inter-byte watchdog, only armed once a frame has started.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                             tmo_cnt <= '0;
    else if (p_state == P_SYNC || byte_valid) tmo_cnt <= '0;
    else                                   tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (p_state != P_SYNC) && !byte_valid && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) p_state <= P_SYNC;
    else       p_state <= p_next;
  end

  always_comb begin
    p_next     = p_state;
    frame_done = 1'b0;
    if (stop_err || tmo_hit) begin
      p_next = P_SYNC;
    end else if (byte_valid) begin
      case (p_state)
        P_SYNC:  if (shreg == SYNC_BYTE) p_next = P_CTRL;
        P_CTRL:  p_next = P_NERR;
        P_NERR:  p_next = P_DATA;
        P_DATA:  p_next = P_CHK;
        P_CHK: begin
          p_next     = P_SYNC;
          frame_done = 1'b1;
        end
        default: p_next = P_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_r <= '0;
      nerr_r <= '0;
      data_r <= '0;
    end else if (byte_valid) begin
      if (p_state == P_CTRL) ctrl_r <= shreg;
      if (p_state == P_NERR) nerr_r <= shreg;
      if (p_state == P_DATA) data_r <= shreg;
    end
  end

  assign frame_good = frame_done && (shreg == (ctrl_r ^ nerr_r ^ data_r)) && (nerr_r <= NERR_MAX);
  assign frame_bad  = frame_done && !frame_good;
  assign hs         = cfg_valid && cfg_ready;

  // A frame landing on a handshake cycle reloads instead of overrunning.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_valid       <= 1'b0;
      cfg_bch_coding  <= 1'b0;
      cfg_gen_noise   <= 1'b0;
      cfg_rand_errors <= 1'b0;
      cfg_num_errors  <= '0;
      cfg_data        <= '0;
    end else if (frame_good && (!cfg_valid || cfg_ready)) begin
      cfg_valid       <= 1'b1;
      cfg_bch_coding  <= ctrl_r[0];
      cfg_gen_noise   <= ctrl_r[1];
      cfg_rand_errors <= ctrl_r[2];
      cfg_num_errors  <= nerr_r;
      cfg_data        <= data_r;
    end else if (hs) begin
      cfg_valid <= 1'b0;
    end
  end

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] n);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_err_cnt <= '0;
      chk_err_cnt   <= '0;
      overrun       <= 1'b0;
    end else if (clr_status) begin
      frame_err_cnt <= '0;
      chk_err_cnt   <= '0;
      overrun       <= 1'b0;
    end else begin
      frame_err_cnt <= sat_add(frame_err_cnt, {1'b0, stop_err} + {1'b0, tmo_hit});
      chk_err_cnt   <= sat_add(chk_err_cnt, {1'b0, frame_bad});
      if (frame_good && cfg_valid && !cfg_ready) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bch_uart_cmd_rx.sv
// Bench for bch_uart_cmd_rx: frame table plus hand-written corner sequences,
// configuration words checked through a scoreboard at each handshake.
module tb_bch_uart_cmd_rx;
  localparam int CPB = 16;
  localparam int TMO = 320;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       uart_rx = 1'b1;
  logic       cfg_ready = 1'b0;
  logic       clr_status = 1'b0;
  logic       cfg_valid, cfg_bch_coding, cfg_gen_noise, cfg_rand_errors, overrun;
  logic [7:0] cfg_num_errors, cfg_data, frame_err_cnt, chk_err_cnt;

  bch_uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO), .MAX_ERRORS(13)) dut (
    .clk(clk), .rstn(rstn), .uart_rx(uart_rx), .cfg_ready(cfg_ready),
    .clr_status(clr_status), .cfg_valid(cfg_valid), .cfg_bch_coding(cfg_bch_coding),
    .cfg_gen_noise(cfg_gen_noise), .cfg_rand_errors(cfg_rand_errors),
    .cfg_num_errors(cfg_num_errors), .cfg_data(cfg_data),
    .frame_err_cnt(frame_err_cnt), .chk_err_cnt(chk_err_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ctrl;
    logic [7:0] nerr;
    logic [7:0] data;
  } cfg_t;

  typedef struct {
    logic [39:0] bytes;
    bit          good;
    cfg_t        exp;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   valid_hi = 0;
  int   exp_frame = 0;
  int   exp_chk = 0;
  cfg_t sb_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop;
    tick(CPB);
    uart_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 4; i >= 0; i--) send_byte(f[i*8 +: 8], 1'b1);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_frame_err"}, int'(frame_err_cnt), exp_frame);
    chk({tag, "_chk_err"}, int'(chk_err_cnt), exp_chk);
  endtask

  // Scoreboard: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rstn && cfg_valid) begin
      valid_hi++;
      if (cfg_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_cfg: got data %0h, none expected", cfg_data);
        end else begin
          cfg_t e;
          e = sb_q.pop_front();
          chk("cfg_word", int'({cfg_rand_errors, cfg_gen_noise, cfg_bch_coding,
                                cfg_num_errors, cfg_data}), int'(e));
        end
      end
    end
  end

  vec_t tbl[6];
  int   vh0;

  initial begin
    tbl[0] = '{40'hA5_05_03_AA_AC, 1'b1, {3'b101, 8'h03, 8'hAA}};
    tbl[1] = '{40'hA5_05_03_AA_AD, 1'b0, '0};
    tbl[2] = '{40'hA5_05_0E_AA_A1, 1'b0, '0};
    tbl[3] = '{40'hA5_FA_0D_3C_CB, 1'b1, {3'b010, 8'h0D, 8'h3C}};
    tbl[4] = '{40'hA5_00_00_00_00, 1'b1, {3'b000, 8'h00, 8'h00}};
    tbl[5] = '{40'hA5_07_00_FF_F8, 1'b1, {3'b111, 8'h00, 8'hFF}};

    tick(3);
    chk("reset_outputs", int'({cfg_valid, cfg_bch_coding, cfg_gen_noise, cfg_rand_errors,
                               cfg_num_errors, cfg_data, overrun}), 0);
    chk_counters("reset");
    rstn = 1'b1;
    tick(5);
    cfg_ready = 1'b1;

    // Table of frames, ready held high.
    for (int i = 0; i < 6; i++) begin
      vh0 = valid_hi;
      if (tbl[i].good) sb_q.push_back(tbl[i].exp);
      else             exp_chk++;
      send_frame(tbl[i].bytes);
      tick(6);
      chk($sformatf("valid_cycles_%0d", i), valid_hi - vh0, tbl[i].good ? 1 : 0);
      chk($sformatf("sb_pending_%0d", i), sb_q.size(), 0);
      chk_counters($sformatf("tbl%0d", i));
    end

    // Bad stop bit, then inter-byte timeout, then resync through junk.
    send_byte(8'hA5, 1'b0);
    tick(4);
    exp_frame++;
    chk_counters("stop_err");
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b1);
    tick(400);
    exp_frame++;
    chk_counters("timeout");
    vh0 = valid_hi;
    send_byte(8'h3C, 1'b1);
    send_byte(8'h11, 1'b1);
    sb_q.push_back(tbl[0].exp);
    send_frame(tbl[0].bytes);
    tick(6);
    chk("resync_valid_cycles", valid_hi - vh0, 1);
    chk_counters("resync");

    // Start-bit glitch shorter than half a bit.
    vh0 = valid_hi;
    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    tick(40);
    chk("glitch_valid_cycles", valid_hi - vh0, 0);
    chk_counters("glitch");
    sb_q.push_back(tbl[3].exp);
    send_frame(tbl[3].bytes);
    tick(6);
    chk("glitch_follow_valid", valid_hi - vh0, 1);

    // Backpressure: second good frame is dropped and flags overrun.
    cfg_ready = 1'b0;
    sb_q.push_back(tbl[0].exp);
    send_frame(tbl[0].bytes);
    send_frame(40'hA5_05_03_55_53);
    tick(4);
    chk("bp_valid", int'(cfg_valid), 1);
    chk("bp_data_held", int'(cfg_data), 'hAA);
    chk("bp_overrun", int'(overrun), 1);
    chk_counters("bp");
    cfg_ready = 1'b1;
    tick(1);
    chk("bp_valid_after_hs", int'(cfg_valid), 0);
    chk("bp_sb_pending", sb_q.size(), 0);
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    exp_frame = 0;
    exp_chk = 0;
    chk("clr_overrun", int'(overrun), 0);
    chk_counters("clr");

    // Reset in the middle of the NERR byte.
    send_frame(tbl[1].bytes);
    tick(4);
    exp_chk++;
    chk_counters("pre_rst");
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b1);
    uart_rx = 1'b0;
    tick(CPB * 3);
    rstn = 1'b0;
    #1;
    chk("midrst_outputs", int'({cfg_valid, cfg_bch_coding, cfg_gen_noise, cfg_rand_errors,
                                cfg_num_errors, cfg_data, overrun}), 0);
    chk("midrst_counters", int'({frame_err_cnt, chk_err_cnt}), 0);
    tick(2);
    uart_rx = 1'b1;
    rstn = 1'b1;
    exp_chk = 0;
    tick(10);
    vh0 = valid_hi;
    sb_q.push_back(tbl[5].exp);
    send_frame(tbl[5].bytes);
    tick(6);
    chk("post_rst_valid_cycles", valid_hi - vh0, 1);
    chk("post_rst_sb_pending", sb_q.size(), 0);
    chk_counters("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bch_uart_cmd_rx.md
# bch_uart_cmd_rx

UART command receiver that sits directly upstream of the BCH top-level control logic. It deserialises 8N1 bytes from the board UART line and parses a fixed 5-byte command frame. It then presents one validated configuration word to the BCH pipeline with a valid/ready handshake: encode enable, noise enable, random-error enable, error count and the 8-bit message. Frame, checksum and overrun events are counted for debug readout.

## Interface
- CLKS_PER_BIT, 5208: clk cycles per UART bit (50 MHz / 9600 baud); must be ≥ 8.
- TIMEOUT_CLKS, 104160: idle clk cycles allowed between bytes inside a frame (20 bit times).
- MAX_ERRORS, 13: largest accepted error count.
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-low reset.
- uart_rx  in  1  asynchronous serial line; idles high.
- cfg_ready  in  1  downstream accepts the configuration.
- clr_status  in  1  one-cycle pulse; clears the counters and `overrun`.
- cfg_valid  out  1  configuration word available.
- cfg_bch_coding  out  1  CTRL[0].
- cfg_gen_noise  out  1  CTRL[1].
- cfg_rand_errors  out  1  CTRL[2].
- cfg_num_errors  out  8  NERR byte.
- cfg_data  out  8  message byte.
- frame_err_cnt  out  8  bad-stop-bit plus timeout events; saturates at 255.
- chk_err_cnt  out  8  checksum-mismatch plus NERR-out-of-range events; saturates at 255.
- overrun  out  1  sticky; a good frame was dropped.

## Operation
- **Synchroniser.** `uart_rx` passes through a 2-FF synchroniser; both FFs reset to 1. A start condition is a falling edge on the synchronised line (previous 1, current 0), so a line stuck low never retriggers.
- **RX FSM states:** RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE → RX_START on a falling edge.
  - RX_START waits CLKS_PER_BIT/2 cycles, then samples. A low sample goes to RX_DATA; a high sample is a glitch and returns to RX_IDLE with nothing counted.
  - RX_DATA samples every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - RX_STOP samples after CLKS_PER_BIT cycles. A high sample pulses internal `byte_valid` for one cycle with the byte. A low sample increments `frame_err_cnt`, emits no byte, and resets the parser to P_SYNC.
  - Both stop-bit cases return to RX_IDLE.
- **Frame format:** 0xA5, CTRL, NERR, DATA, CHK, where CHK = CTRL ^ NERR ^ DATA. CTRL[7:3] are ignored.
- **Parser states:** P_SYNC, P_CTRL, P_NERR, P_DATA, P_CHK.
  - P_SYNC discards every byte other than 0xA5.
  - Each subsequent byte advances one state. P_CHK always returns to P_SYNC.
- **Frame validation.** A frame is good when CHK matches and NERR ≤ MAX_ERRORS. Otherwise `chk_err_cnt` increments and the frame is dropped.
- **Timeout.** In any parser state other than P_SYNC, a counter reloads on each `byte_valid`. If it reaches TIMEOUT_CLKS, the parser returns to P_SYNC and `frame_err_cnt` increments.
- **Output handshake.**
  - A good frame loads the cfg_* registers and sets `cfg_valid`.
  - `cfg_valid` holds, with cfg_* stable, until `cfg_valid && cfg_ready` is sampled at a rising edge.
  - A good frame completing while `cfg_valid=1` and `cfg_ready=0` is dropped and sets `overrun`.
  - A good frame completing in the same cycle as a handshake is loaded; `cfg_valid` stays 1 and no overrun is flagged.
- **Status clear.** `clr_status` zeroes both counters and `overrun`. If it coincides with an increment, the clear wins.

## Timing
- **Reset values:** all outputs 0; RX_IDLE; P_SYNC; synchroniser FFs 1. Reset mid-frame or mid-byte abandons that data; there is no partial output.
- **Sample points.** The start sample falls CLKS_PER_BIT/2 cycles after the synchronised falling edge. Data bit k is sampled (k+1)·CLKS_PER_BIT cycles after the start sample. The stop bit is sampled 9·CLKS_PER_BIT cycles after the start sample.
- **Byte latency.** `byte_valid` is asserted in the cycle after the stop sample.
- **Frame latency.** `cfg_valid` rises in the cycle after the CHK `byte_valid`. Counter increments are also visible in that cycle.
- **Handshake release.** `cfg_valid` falls in the cycle after a handshake, unless a new frame loads in that same cycle.
- **Throughput.** Back-to-back bytes need no idle time; one stop bit is sufficient.

## Test plan
All scenarios use CLKS_PER_BIT=16 and TIMEOUT_CLKS=320.
1. **Good frame:** send A5 05 03 AA AC with `cfg_ready=1` → `cfg_valid` high for exactly one cycle with `bch_coding=1`, `gen_noise=0`, `rand_errors=1`, `num_errors=3`, `data=0xAA`. Both counters stay 0.
2. **Rejected frames:** send A5 05 03 AA AD (bad CHK), then A5 05 0E AA A1 (NERR=14, correct CHK) → no `cfg_valid`, `chk_err_cnt=2`.
3. **Stop-bit error and timeout:**
   - Send A5 with stop bit driven 0 → `frame_err_cnt=1`.
   - Send A5 05, then idle for 400 cycles → `frame_err_cnt=2`.
   - Send 3C 11 A5 05 03 AA AC → exactly one valid config.
4. **Start glitch:** hold `uart_rx` low for 4 cycles, then high → no byte, no counter change. A following good frame is accepted.
5. **Backpressure:**
   - With `cfg_ready=0`, send good frames data=0xAA (chk AC), then data=0x55 (chk 53) → `cfg_data` stays 0xAA and `overrun=1`.
   - Raise `cfg_ready` → one handshake; `cfg_valid` low next cycle.
   - Pulse `clr_status` → `overrun=0`.
6. **Reset mid-frame:** assert `rstn=0` during the NERR byte → all outputs 0. After release, a complete good frame is accepted normally.
